board_game_ctrl: RTL and testbench

Parametrised N×N, K-in-a-row two-player game controller. It replaces the fixed 3×3 tic-tac-toe game-state logic. It accepts one-cycle move requests from the keypad decoder and keeps separate X and O board planes. After every move it scans the board sequentially for a K-long line or a full board, then reports turn and result to the display modules. It also drives the two-digit 7-segment "P1"/"P2" turn indicator.

---
 rtl/board_game_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_board_game_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_ctrl.sv
// N x N, K-in-a-row two-player game controller.
// Sequential line scan after each move, plus P1/P2 display.
module board_game_ctrl #(
  parameter int N        = 3,
  parameter int K        = 3,
  parameter int SCAN_DIV = 25000,
  parameter int PW       = $clog2(N*N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [PW-1:0]  key_pos,
  input  logic           new_game,
  output logic [N*N-1:0] board_x,
  output logic [N*N-1:0] board_o,
  output logic           turn_o,
  output logic [1:0]     result,
  output logic           busy,
  output logic           move_err,
  output logic [6:0]     seg_txt,
  output logic [7:0]     seg_com
);

  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(NN);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] G_P    = 7'b1110011;
  localparam logic [6:0] G_ONE  = 7'b0000110;
  localparam logic [6:0] G_TWO  = 7'b1011011;
  localparam logic [6:0] G_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    CHECK,
    OVER
  } state_t;

  state_t          state_q, state_d;
  logic [NN-1:0]   bx_q, bx_d;
  logic [NN-1:0]   bo_q, bo_d;
  logic            turn_q, turn_d;
  logic            mover_q, mover_d;
  logic [1:0]      res_q, res_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic [1:0]      dir_q, dir_d;
  logic [DW-1:0]   div_q, div_d;
  logic            dig_q, dig_d;
  logic [6:0]      txt_q, txt_d;
  logic [7:0]      com_q, com_d;

  logic [NN-1:0]   plane;
  int              r, c, dr, dc;
  logic [IW-1:0]   idx;
  logic            hit;
  logic            legal;
  logic            last;

  // Does the current (start, direction) line lie fully in the mover's plane
  always_comb begin
    plane = mover_q ? bo_q : bx_q;
    r  = int'(r_q);
    c  = int'(c_q);
    dr = 1;
    dc = 0;
    unique case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    hit = (r + (K-1)*dr < N) &&
          (c + (K-1)*dc < N) &&
          (c + (K-1)*dc >= 0);
    idx = '0;
    for (int k = 0; k < K; k++) begin
      idx = hit ? IW'((r + k*dr)*N + c + k*dc) : '0;
      if (!plane[idx]) hit = 1'b0;
    end
  end

  // Move legality and end-of-scan detection
  always_comb begin
    legal = 1'b0;
    if (32'(key_pos) < NN)
      legal = !(bx_q[key_pos] | bo_q[key_pos]);
    last = (r_q == CW'(N-1)) &&
           (c_q == CW'(N-1)) &&
           (dir_q == 2'd3);
  end

  // Next state: game FSM, scan walk, display mux
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    bo_d    = bo_q;
    turn_d  = turn_q;
    mover_d = mover_q;
    res_d   = res_q;
    err_d   = 1'b0;
    pos_d   = pos_q;
    r_d     = r_q;
    c_d     = c_q;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (legal) begin
            pos_d   = key_pos;
            state_d = PLACE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PLACE: begin
        mover_d = turn_q;
        if (turn_q) bo_d[pos_q] = 1'b1;
        else        bx_d[pos_q] = 1'b1;
        r_d     = '0;
        c_d     = '0;
        dir_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (hit) begin
          res_d   = mover_q ? 2'b10 : 2'b01;
          state_d = OVER;
        end else if (last) begin
          if (&(bx_q | bo_q)) begin
            res_d   = 2'b11;
            state_d = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end else if (dir_q == 2'd3) begin
          dir_d = 2'd0;
          if (c_q == CW'(N-1)) begin
            c_d = '0;
            r_d = r_q + CW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      OVER: begin
      end
    endcase

    if (new_game) begin
      state_d = IDLE;
      bx_d    = '0;
      bo_d    = '0;
      turn_d  = 1'b0;
      res_d   = 2'b00;
      err_d   = 1'b0;
    end

    busy_d = (state_d == PLACE) || (state_d == CHECK);

    if (div_q == DW'(SCAN_DIV-1)) begin
      div_d = '0;
      dig_d = ~dig_q;
    end else begin
      div_d = div_q + DW'(1);
      dig_d = dig_q;
    end

    com_d = dig_d ? 8'b10111111 : 8'b01111111;
    if (res_d == 2'b11)      txt_d = G_DASH;
    else if (!dig_d)         txt_d = G_P;
    else if (res_d == 2'b01) txt_d = G_ONE;
    else if (res_d == 2'b10) txt_d = G_TWO;
    else                     txt_d = turn_d ? G_TWO : G_ONE;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bx_q    <= '0;
      bo_q    <= '0;
      turn_q  <= 1'b0;
      mover_q <= 1'b0;
      res_q   <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      dir_q   <= '0;
      div_q   <= '0;
      dig_q   <= 1'b0;
      txt_q   <= G_P;
      com_q   <= 8'b01111111;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      bo_q    <= bo_d;
      turn_q  <= turn_d;
      mover_q <= mover_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      r_q     <= r_d;
      c_q     <= c_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
      txt_q   <= txt_d;
      com_q   <= com_d;
    end
  end

  assign board_x  = bx_q;
  assign board_o  = bo_q;
  assign turn_o   = turn_q;
  assign result   = res_q;
  assign busy     = busy_q;
  assign move_err = err_q;
  assign seg_txt  = txt_q;
  assign seg_com  = com_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Bench for board_game_ctrl: 3x3/K3 and 5x5/K4 instances
// against a cycle model of the game rules.
module tb_board_game_ctrl;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       kv3, ng3;
  logic [3:0] kp3;
  logic [8:0] bx3, bo3;
  logic       t3, busy3, err3;
  logic [1:0] r3;
  logic [6:0] st3;
  logic [7:0] sc3;

  logic        kv5, ng5;
  logic [4:0]  kp5;
  logic [24:0] bx5, bo5;
  logic        t5, busy5, err5;
  logic [1:0]  r5;
  logic [6:0]  st5;
  logic [7:0]  sc5;

  board_game_ctrl #(.N(3), .K(3), .SCAN_DIV(SD)) u3 (
    .clk(clk), .rst(rst),
    .key_valid(kv3), .key_pos(kp3), .new_game(ng3),
    .board_x(bx3), .board_o(bo3), .turn_o(t3),
    .result(r3), .busy(busy3), .move_err(err3),
    .seg_txt(st3), .seg_com(sc3)
  );

  board_game_ctrl #(.N(5), .K(4), .SCAN_DIV(SD)) u5 (
    .clk(clk), .rst(rst),
    .key_valid(kv5), .key_pos(kp5), .new_game(ng5),
    .board_x(bx5), .board_o(bo5), .turn_o(t5),
    .result(r5), .busy(busy5), .move_err(err5),
    .seg_txt(st5), .seg_com(sc5)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  logic [63:0] mbx[2], mbo[2];
  int mturn[2], mres[2], mrem[2], mhit[2];
  int mpos[2], mcnt[2];
  bit mplaced[2], merr[2], mdig[2];

  task automatic cmp(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  // 1-based index of the first hitting (start,dir) pair
  function automatic int first_hit(input int n, input int k,
                                   input logic [63:0] p);
    int dr, dc, rr, cc;
    bit ok;
    for (int s = 0; s < n*n; s++) begin
      for (int d = 0; d < 4; d++) begin
        dr = (d == 0) ? 0 : 1;
        dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
        ok = 1;
        for (int i = 0; i < k; i++) begin
          rr = s / n + i * dr;
          cc = s % n + i * dc;
          if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 0;
          else if (!p[rr*n+cc]) ok = 0;
        end
        if (ok) return s * 4 + d + 1;
      end
    end
    return 0;
  endfunction

  function automatic logic [6:0] glyph(input int res,
                                       input int trn,
                                       input bit dig);
    if (res == 3) return 7'b1000000;
    if (!dig) return 7'b1110011;
    if (res == 1) return 7'b0000110;
    if (res == 2) return 7'b1011011;
    return (trn != 0) ? 7'b1011011 : 7'b0000110;
  endfunction

  task automatic mstep(input int u, input bit r, input bit kv,
                       input int kp, input bit ng);
    int n, k;
    logic [63:0] mask, pl;
    n = (u == 0) ? 3 : 5;
    k = (u == 0) ? 3 : 4;
    mask = (64'd1 << (n*n)) - 64'd1;
    merr[u] = 0;
    if (r) begin
      mbx[u] = 0; mbo[u] = 0; mturn[u] = 0; mres[u] = 0;
      mrem[u] = 0; mcnt[u] = 0; mdig[u] = 0;
      return;
    end
    if (mcnt[u] == SD - 1) begin
      mcnt[u] = 0;
      mdig[u] = ~mdig[u];
    end else begin
      mcnt[u]++;
    end
    if (ng) begin
      mbx[u] = 0; mbo[u] = 0; mturn[u] = 0;
      mres[u] = 0; mrem[u] = 0;
    end else if (mrem[u] > 0) begin
      if (!mplaced[u]) begin
        if (mturn[u] != 0) mbo[u][mpos[u]] = 1'b1;
        else mbx[u][mpos[u]] = 1'b1;
        mplaced[u] = 1;
      end
      mrem[u]--;
      if (mrem[u] == 0) begin
        if (mhit[u] > 0) mres[u] = (mturn[u] != 0) ? 2 : 1;
        else if (((mbx[u] | mbo[u]) & mask) == mask) mres[u] = 3;
        else mturn[u] = 1 - mturn[u];
      end
    end else if (mres[u] == 0 && kv) begin
      if (kp < n*n && !mbx[u][kp] && !mbo[u][kp]) begin
        pl = ((mturn[u] != 0) ? mbo[u] : mbx[u]) | (64'd1 << kp);
        mhit[u] = first_hit(n, k, pl);
        mrem[u] = ((mhit[u] > 0) ? mhit[u] : 4*n*n) + 1;
        mpos[u] = kp;
        mplaced[u] = 0;
      end else begin
        merr[u] = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mstep(0, rst, kv3, int'(kp3), ng3);
      mstep(1, rst, kv5, int'(kp5), ng5);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("n3.board_x", 64'(bx3), mbx[0] & 64'h1ff);
        cmp("n3.board_o", 64'(bo3), mbo[0] & 64'h1ff);
        cmp("n3.turn", 64'(t3), 64'(mturn[0]));
        cmp("n3.result", 64'(r3), 64'(mres[0]));
        cmp("n3.busy", 64'(busy3), 64'(mrem[0] > 0));
        cmp("n3.move_err", 64'(err3), 64'(merr[0]));
        cmp("n3.seg_txt", 64'(st3),
            64'(glyph(mres[0], mturn[0], mdig[0])));
        cmp("n3.seg_com", 64'(sc3),
            mdig[0] ? 64'hbf : 64'h7f);
        cmp("n5.board_x", 64'(bx5), mbx[1] & 64'h1ffffff);
        cmp("n5.board_o", 64'(bo5), mbo[1] & 64'h1ffffff);
        cmp("n5.turn", 64'(t5), 64'(mturn[1]));
        cmp("n5.result", 64'(r5), 64'(mres[1]));
        cmp("n5.busy", 64'(busy5), 64'(mrem[1] > 0));
        cmp("n5.move_err", 64'(err5), 64'(merr[1]));
        cmp("n5.seg_txt", 64'(st5),
            64'(glyph(mres[1], mturn[1], mdig[1])));
        cmp("n5.seg_com", 64'(sc5),
            mdig[1] ? 64'hbf : 64'h7f);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int u, input int p, output logic e);
    int n;
    tick();
    if (u == 0) begin kv3 = 1; kp3 = 4'(p); end
    else begin kv5 = 1; kp5 = 5'(p); end
    tick();
    kv3 = 0;
    kv5 = 0;
    e = (u == 0) ? err3 : err5;
    n = 0;
    while (((u == 0) ? busy3 : busy5) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL key_timeout u=%0d actual=busy required=idle", u);
    end
  endtask

  task automatic newgame(input int u);
    tick();
    if (u == 0) ng3 = 1; else ng5 = 1;
    tick();
    ng3 = 0;
    ng5 = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [7:0] sc_save;
    logic [6:0] d1;
    rst = 1;
    kv3 = 0; ng3 = 0; kp3 = 0;
    kv5 = 0; ng5 = 0; kp5 = 0;
    tick();
    chk_en = 1;
    tick();
    cmp("rst.seg_com", 64'(sc3), 64'h7f);
    cmp("rst.seg_txt", 64'(st3), 64'h73);
    cmp("rst.result", 64'(r3), 64'd0);
    cmp("rst.board", 64'({bx3, bo3}), 64'd0);
    rst = 0;

    key(0, 0, e); key(0, 3, e); key(0, 1, e);
    key(0, 4, e); key(0, 2, e);
    cmp("xwin.board_x", 64'(bx3), 64'h007);
    cmp("xwin.board_o", 64'(bo3), 64'h018);
    cmp("xwin.result", 64'(r3), 64'd1);
    cmp("xwin.turn", 64'(t3), 64'd0);
    cmp("xwin.model", 64'(mres[0]), 64'd1);
    key(0, 5, e);
    cmp("over.ignored_err", 64'(e), 64'd0);
    cmp("over.board_o", 64'(bo3), 64'h018);

    newgame(0);
    cmp("ng.board", 64'({bx3, bo3}), 64'd0);
    key(0, 4, e);
    cmp("legal.err", 64'(e), 64'd0);
    d1 = 7'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sc3 == 8'b10111111) d1 = st3;
    end
    cmp("p2.digit1", 64'(d1), 64'h5b);
    key(0, 4, e);
    cmp("occupied.err", 64'(e), 64'd1);
    cmp("occupied.board_o", 64'(bo3), 64'd0);
    cmp("occupied.turn", 64'(t3), 64'd1);
    key(0, 9, e);
    cmp("range.err", 64'(e), 64'd1);

    newgame(0);
    key(0, 0, e); key(0, 1, e); key(0, 2, e);
    key(0, 4, e); key(0, 3, e); key(0, 5, e);
    key(0, 7, e); key(0, 6, e); key(0, 8, e);
    cmp("draw.result", 64'(r3), 64'd3);
    cmp("draw.seg_a", 64'(st3), 64'h40);
    sc_save = sc3;
    repeat (SD) tick();
    cmp("draw.seg_b", 64'(st3), 64'h40);
    cmp("draw.other_digit", 64'(sc3),
        64'(sc_save ^ 8'b11000000));

    newgame(1);
    key(1, 3, e); key(1, 4, e); key(1, 7, e); key(1, 8, e);
    key(1, 11, e); key(1, 12, e); key(1, 0, e); key(1, 16, e);
    cmp("odiag.result", 64'(r5), 64'd2);
    cmp("odiag.board_o", 64'(bo5), 64'h11110);
    cmp("odiag.board_x", 64'(bx5), 64'h889);
    cmp("odiag.model", 64'(mres[1]), 64'd2);
    newgame(1);
    key(1, 3, e); key(1, 10, e); key(1, 4, e); key(1, 15, e);
    key(1, 5, e); key(1, 22, e); key(1, 6, e);
    cmp("wrap.result", 64'(r5), 64'd0);
    cmp("wrap.turn", 64'(t5), 64'd1);

    newgame(0);
    tick(); kv3 = 1; kp3 = 4'd8;
    tick(); kv3 = 0;
    repeat (5) tick();
    cmp("midchk.busy", 64'(busy3), 64'd1);
    cmp("midchk.board_x", 64'(bx3), 64'h100);
    ng3 = 1;
    tick(); ng3 = 0;
    cmp("abort.busy", 64'(busy3), 64'd0);
    cmp("abort.result", 64'(r3), 64'd0);
    cmp("abort.board", 64'({bx3, bo3}), 64'd0);
    cmp("abort.turn", 64'(t3), 64'd0);

    tick(); kv3 = 1; kp3 = 4'd2;
    tick(); kv3 = 0;
    repeat (6) tick();
    rst = 1;
    tick(); rst = 0;
    cmp("rstchk.busy", 64'(busy3), 64'd0);
    cmp("rstchk.board", 64'({bx3, bo3}), 64'd0);
    cmp("rstchk.seg_com", 64'(sc3), 64'h7f);

    for (int i = 0; i < 4000; i++) begin
      tick();
      kv3 = ($urandom % 3) == 0;
      kp3 = 4'($urandom_range(0, 15));
      ng3 = ($urandom % 80 == 0) ||
            (mres[0] != 0 && $urandom % 6 == 0);
      kv5 = ($urandom % 3) == 0;
      kp5 = 5'($urandom_range(0, 31));
      ng5 = ($urandom % 150 == 0) ||
            (mres[1] != 0 && $urandom % 6 == 0);
      rst = ($urandom % 900 == 0);
    end
    tick();
    kv3 = 0; ng3 = 0; kv5 = 0; ng5 = 0; rst = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
